serial_adder8: RTL and testbench
================================

# serial_adder8

Bit-serial adder engine that drives the single-bit full-adder cell of the 8-bit adder datapath. It accepts two operands and a carry-in through a valid/ready handshake. It then feeds one bit pair per clock, LSB first, into the full-adder cell, registering the carry between bits. After WIDTH bit-cycles it presents the assembled sum and carry-out on a valid/ready output port. It is the sequential front-end that the full-adder cell is instantiated under.

## Interface
- WIDTH, 8, operand/sum width in bits (≥2); bit counter is $clog2(WIDTH) bits wide.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands on a, b, ci are valid.
- in_ready  output  1  engine can accept operands (high only in IDLE).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in for bit 0.
- out_valid  output  1  S/cout hold a completed result (high only in DONE).
- out_ready  input  1  consumer accepts result.
- S  output  WIDTH  registered sum.
- cout  output  1  registered carry-out of MSB.

## Operation
- One full-adder cell is instantiated: inputs a_sh[0], b_sh[0], carry_q; outputs sum bit and next carry.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: a_sh<=a, b_sh<=b, carry_q<=ci, cnt<=0, S<=0, go RUN.
- RUN: each cycle S<={fa_sum, S[WIDTH-1:1]}, carry_q<=fa_cout, a_sh/b_sh shift right by 1 (zero fill), cnt<=cnt+1. The cycle with cnt==WIDTH-1 also loads cout<=fa_cout and goes to DONE.
- DONE: out_valid=1. S and cout are held stable. On out_ready, go IDLE. in_ready stays 0, so there is no same-cycle re-accept; the next accept is earliest one cycle after return to IDLE.
- Arithmetic: {cout,S} == a + b + ci, modulo 2^(WIDTH+1), exact.
- in_valid is ignored outside IDLE. Inputs are sampled only on the accept edge; later changes to a/b/ci have no effect.
- out_ready is ignored outside DONE.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, S=0, cout=0, carry_q=0, cnt=0, shift regs=0.
- Latency: accept on edge E0. RUN occupies edges E1..E(WIDTH). out_valid rises after edge E(WIDTH) (8 cycles for WIDTH=8).
- Throughput: one operation per WIDTH+2 cycles minimum (accept, WIDTH bit-cycles, handshake-out).
- Backpressure: out_valid stays high with S/cout constant until out_ready is sampled high.
- Reset asserted mid-RUN or mid-DONE: all state clears immediately, asynchronously. The partial result is discarded and no out_valid pulse follows.
- All outputs are registered except in_ready and out_valid, which are decoded from the state register only (no combinational path from inputs).

## Configuration
- SERIAL_ADDER_SUB_EN defined: adds input port sub (1 bit, sampled on accept).
  - When sub=1, b is inverted at load and carry_q is loaded with 1 (ci is ignored), giving S=a−b.
  - cout=1 means no borrow.
- Macro undefined: the sub port does not exist and the block behaves as a pure adder.

## Test plan
- Reset, then a=0x5A, b=0x3C, ci=0 → after 8 RUN cycles, out_valid=1, S=0x96, cout=0.
- a=0xFF, b=0x01, ci=0 → S=0x00, cout=1 (full carry ripple across all bits).
- a=0xFF, b=0xFF, ci=1 → S=0xFF, cout=1. Also check in_ready=0 for all cycles between accept and output handshake.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → S/cout unchanged, in_valid pulses ignored. Then out_ready=1 → IDLE next cycle, in_ready=1.
- Assert rst_n=0 at RUN cycle 4 → all outputs at reset values the same cycle. After release, a=0x01, b=0x02, ci=0 → S=0x03, cout=0.
- With SERIAL_ADDER_SUB_EN: a=0x10, b=0x01, sub=1 → S=0x0F, cout=1. Then a=0x01, b=0x02, sub=1 → S=0xFF, cout=0.

Source files
------------

// File: rtl/serial_adder8_if.sv
// rtl/serial_adder8_if.sv - operand/result handshake bundle for serial_adder8 (sub port present when SERIAL_ADDER_SUB_EN is defined)
interface serial_adder8_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output in_valid, a, b, ci, sub, out_ready,
                    input  in_ready, out_valid, S, cout);
    modport slave  (input  in_valid, a, b, ci, sub, out_ready,
                    output in_ready, out_valid, S, cout);
`else
    modport master (output in_valid, a, b, ci, out_ready,
                    input  in_ready, out_valid, S, cout);
    modport slave  (input  in_valid, a, b, ci, out_ready,
                    output in_ready, out_valid, S, cout);
`endif
endinterface

// File: rtl/serial_adder8.sv
// rtl/serial_adder8.sv - bit-serial adder engine around a single full-adder cell; SERIAL_ADDER_SUB_EN adds a subtract mode
module serial_adder8_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder8 #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder8_if.slave bus
);
    localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, sum_q;
    logic             carry_q, cout_q;
    logic [CW-1:0]    cnt;
    logic             fa_sum, fa_cout;
    logic             in_ready_c, out_valid_c;
    logic             accept, last_bit;
    logic             sub_mode;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_mode = bus.sub;
`else
    assign sub_mode = 1'b0;
`endif

    serial_adder8_fa u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign accept   = bus.in_valid && in_ready_c;
    assign last_bit = (state == RUN) && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Handshake outputs decode the state register only, so no input reaches them combinationally.
    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: invert b at load and force the initial carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            a_sh    <= bus.a;
            b_sh    <= bus.b ^ {WIDTH{sub_mode}};
            carry_q <= sub_mode ? 1'b1 : bus.ci;
            cnt     <= '0;
            sum_q   <= '0;
        end else if (state == RUN) begin
            sum_q   <= {fa_sum, sum_q[WIDTH-1:1]};
            carry_q <= fa_cout;
            a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
            cnt     <= cnt + 1'b1;
            if (last_bit) cout_q <= fa_cout;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.S         = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_serial_adder8.sv
// tb/tb_serial_adder8.sv - scoreboard bench for serial_adder8 (subtract cases when SERIAL_ADDER_SUB_EN is defined)
module tb_serial_adder8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [8:0] exp_q[$];
    logic [8:0] cur;

    serial_adder8_if #(.WIDTH(8)) bus ();
    serial_adder8 #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sub);
        logic [8:0] e;
        if (sub) e = {1'b0, a} + {1'b0, ~b} + 9'd1;
        else     e = {1'b0, a} + {1'b0, b} + {8'd0, ci};
        bus.a = a; bus.b = b; bus.ci = ci;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = sub;
`endif
        bus.in_valid = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = 8'($urandom); bus.b = 8'($urandom); bus.ci = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = 1'($urandom);
`endif
    endtask

    task automatic wait_result(input string tag);
        int  edges = 0;
        bit  rdy_bad = 0;
        while (!bus.out_valid && edges < 20) begin
            if (bus.in_ready !== 1'b0) rdy_bad = 1;
            @(negedge clk);
            edges++;
        end
        n_cmp++;
        if (edges !== 8) begin
            n_bad++;
            $display("FAIL %s latency: got %0d edges, required 8", tag, edges);
        end
        n_cmp++;
        if (rdy_bad) begin
            n_bad++;
            $display("FAIL %s in_ready_busy: got 1 during run, required 0", tag);
        end
        cur = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1xx;
        n_cmp++;
        if (bus.S !== cur[7:0]) begin
            n_bad++;
            $display("FAIL %s sum: got %h, required %h", tag, bus.S, cur[7:0]);
        end
        n_cmp++;
        if (bus.cout !== cur[8]) begin
            n_bad++;
            $display("FAIL %s cout: got %b, required %b", tag, bus.cout, cur[8]);
        end
    endtask

    task automatic handshake_out(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s return_idle: got in_ready=%b out_valid=%b, required 1/0",
                     tag, bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.S !== 8'h00 || bus.cout !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got rdy=%b vld=%b S=%h cout=%b, required 1 0 00 0",
                     bus.in_ready, bus.out_valid, bus.S, bus.cout);
        end
    endtask

    task automatic test_add;
        logic [7:0] ta[3] = '{8'h5A, 8'hFF, 8'hFF};
        logic [7:0] tb[3] = '{8'h3C, 8'h01, 8'hFF};
        logic       tc[3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            start_op(ta[i], tb[i], tc[i], 1'b0);
            wait_result($sformatf("add%0d", i));
            handshake_out($sformatf("add%0d", i));
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 6; i++) begin
            start_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            wait_result($sformatf("rand%0d", i));
            handshake_out($sformatf("rand%0d", i));
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] s_hold;
        logic       c_hold;
        bit         bad = 0;
        start_op(8'h33, 8'h44, 1'b1, 1'b0);
        wait_result("bp");
        s_hold = cur[7:0];
        c_hold = cur[8];
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.a = 8'($urandom); bus.b = 8'($urandom);
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.S !== s_hold || bus.cout !== c_hold) bad = 1;
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL bp_hold: got vld=%b rdy=%b S=%h cout=%b, required 1 0 %h %b",
                     bus.out_valid, bus.in_ready, bus.S, bus.cout, s_hold, c_hold);
        end
        handshake_out("bp");
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_no_stray: got rdy=%b vld=%b, required 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_run;
        bit seen = 0;
        start_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (bus.S === 8'h00) begin
            n_bad++;
            $display("FAIL mid_run_partial: got S=%h, required nonzero partial", bus.S);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.S !== 8'h00 || bus.cout !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got rdy=%b vld=%b S=%h cout=%b, required 1 0 00 0",
                     bus.in_ready, bus.out_valid, bus.S, bus.cout);
        end
        void'(exp_q.pop_back());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL reset_discard: got out_valid=1 after reset, required 0");
        end
        start_op(8'h01, 8'h02, 1'b0, 1'b0);
        wait_result("post_reset");
        handshake_out("post_reset");
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        start_op(8'h10, 8'h01, 1'b0, 1'b1);
        wait_result("sub0");
        handshake_out("sub0");
        start_op(8'h01, 8'h02, 1'b1, 1'b1);
        wait_result("sub1");
        handshake_out("sub1");
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.ci = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_add();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
